// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter for the single-port cache data array.
// Round-robin between core (A) and refill engine (B), with B burst lock.
module data_mem_arbiter #(
    parameter int INDEX_WIDTH = 4,
    parameter int CHAN_WIDTH  = 3,
    parameter int DATA_WIDTH  = 128,
    parameter int MAX_LOCK    = 8
) (
    input  logic                   clk,
    input  logic                   rsta,
    input  logic                   a_req,
    input  logic                   a_wr,
    input  logic [INDEX_WIDTH-1:0] a_index,
    input  logic [CHAN_WIDTH-1:0]  a_chan,
    input  logic [DATA_WIDTH-1:0]  a_wdata,
    output logic                   a_gnt,
    output logic                   a_rvalid,
    output logic [DATA_WIDTH-1:0]  a_rdata,
    input  logic                   b_req,
    input  logic                   b_wr,
    input  logic [INDEX_WIDTH-1:0] b_index,
    input  logic [CHAN_WIDTH-1:0]  b_chan,
    input  logic [DATA_WIDTH-1:0]  b_wdata,
    input  logic                   b_lock,
    output logic                   b_gnt,
    output logic                   b_rvalid,
    output logic [DATA_WIDTH-1:0]  b_rdata,
    output logic [INDEX_WIDTH-1:0] mem_index,
    output logic [CHAN_WIDTH-1:0]  mem_chan,
    output logic                   mem_wr,
    output logic [DATA_WIDTH-1:0]  mem_din,
    input  logic [DATA_WIDTH-1:0]  mem_dout,
    output logic                   mem_rst
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    // A lock of a single beat never needs the LOCK state.
    localparam logic LOCK_EN = (MAX_LOCK > 1);

    localparam logic ST_RR   = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    logic          r_state;
    logic          r_last_b;
    logic [CW-1:0] r_lock_cnt;
    logic          r_rst_q;
    logic          r_a_rd;
    logic          r_b_rd;

    logic          w_blk;
    logic          w_a_gnt;
    logic          w_b_gnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_lock_done;

    // Grants are held off during reset and for one cycle after it.
    assign w_blk       = rsta | r_rst_q;
    assign w_cnt_nxt   = r_lock_cnt + CNT_ONE;
    assign w_lock_done = (w_cnt_nxt >= LOCK_MAX);

    // Grant selection: LOCK favours B, RR alternates on contention.
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (!w_blk) begin
            if (r_state == ST_LOCK) begin
                w_b_gnt = b_req;
            end else if (a_req && b_req) begin
                w_a_gnt = r_last_b;
                w_b_gnt = !r_last_b;
            end else begin
                w_a_gnt = a_req;
                w_b_gnt = b_req;
            end
        end
    end

    assign a_gnt = w_a_gnt;
    assign b_gnt = w_b_gnt;

    // Array port mux; with no grant the A fields pass through harmlessly.
    always_comb begin
        mem_wr    = 1'b0;
        mem_index = a_index;
        mem_chan  = a_chan;
        mem_din   = a_wdata;
        if (w_b_gnt) begin
            mem_wr    = b_wr;
            mem_index = b_index;
            mem_chan  = b_chan;
            mem_din   = b_wdata;
        end else if (w_a_gnt) begin
            mem_wr    = a_wr;
        end
    end

    assign mem_rst = rsta;

    // Arbitration state: round-robin pointer and B lock window.
    always_ff @(posedge clk) begin
        if (rsta) begin
            r_state    <= ST_RR;
            r_last_b   <= 1'b1;
            r_lock_cnt <= '0;
        end else begin
            if (w_a_gnt) begin
                r_last_b <= 1'b0;
            end
            if (w_b_gnt) begin
                r_last_b <= 1'b1;
            end
            unique case (r_state)
                ST_RR: begin
                    if (w_b_gnt && b_lock && LOCK_EN) begin
                        r_state    <= ST_LOCK;
                        r_lock_cnt <= CNT_ONE;
                    end
                end
                ST_LOCK: begin
                    if (!b_req) begin
                        r_state    <= ST_RR;
                        r_lock_cnt <= '0;
                        r_last_b   <= 1'b1;
                    end else if (w_b_gnt) begin
                        if (!b_lock || w_lock_done) begin
                            r_state    <= ST_RR;
                            r_lock_cnt <= '0;
                        end else begin
                            r_lock_cnt <= w_cnt_nxt;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_RR;
                    r_lock_cnt <= '0;
                end
            endcase
        end
    end

    // Remember that reset was active last cycle to hold grants off.
    always_ff @(posedge clk) begin
        r_rst_q <= rsta;
    end

    // Read-owner flags steer the next-cycle array output.
    always_ff @(posedge clk) begin
        if (rsta) begin
            r_a_rd <= 1'b0;
            r_b_rd <= 1'b0;
        end else begin
            r_a_rd <= w_a_gnt & ~a_wr;
            r_b_rd <= w_b_gnt & ~b_wr;
        end
    end

    // A response in flight when reset hits is dropped immediately.
    assign a_rvalid = r_a_rd & ~rsta;
    assign b_rvalid = r_b_rd & ~rsta;
    assign a_rdata  = mem_dout;
    assign b_rdata  = mem_dout;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural data array.
// MAX_LOCK is set to 4 so lock timeout is reachable quickly.
module tb_data_mem_arbiter;

    localparam int IW = 4;
    localparam int CW = 3;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rsta;
    logic          a_req, a_wr, a_gnt, a_rvalid;
    logic [IW-1:0] a_index;
    logic [CW-1:0] a_chan;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_wr, b_lock, b_gnt, b_rvalid;
    logic [IW-1:0] b_index;
    logic [CW-1:0] b_chan;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [IW-1:0] mem_index;
    logic [CW-1:0] mem_chan;
    logic          mem_wr, mem_rst;
    logic [DW-1:0] mem_din, mem_dout;

    logic [DW-1:0] mem [8][16];

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [DW-1:0] DA5 = {16{8'hA5}};
    localparam logic [DW-1:0] D12 = {8{16'h1212}};
    localparam logic [DW-1:0] D21 = {8{16'h2121}};
    localparam logic [DW-1:0] D77 = {8{16'h7777}};

    data_mem_arbiter #(
        .INDEX_WIDTH(IW), .CHAN_WIDTH(CW),
        .DATA_WIDTH(DW), .MAX_LOCK(4)
    ) dut (
        .clk(clk), .rsta(rsta),
        .a_req(a_req), .a_wr(a_wr), .a_index(a_index),
        .a_chan(a_chan), .a_wdata(a_wdata), .a_gnt(a_gnt),
        .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_index(b_index),
        .b_chan(b_chan), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_index(mem_index), .mem_chan(mem_chan),
        .mem_wr(mem_wr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_rst(mem_rst)
    );

    always #5 clk = ~clk;

    // Single-port array with registered read output.
    always @(posedge clk) begin
        if (mem_rst) mem_dout <= '0;
        else if (mem_wr) mem[mem_chan][mem_index] <= mem_din;
        else mem_dout <= mem[mem_chan][mem_index];
    end

    function automatic logic [DW-1:0] burst_data(input int i);
        return DW'(32'h7000 + i);
    endfunction

    task automatic test_reset;
        a_req = 1; a_wr = 1; a_index = 3; a_chan = 5; a_wdata = DA5;
        rsta = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++; if (a_gnt !== 1'b0) $display("FAIL rst_a_gnt got=%b exp=0", a_gnt); else n_pass++;
            n_checks++; if (b_gnt !== 1'b0) $display("FAIL rst_b_gnt got=%b exp=0", b_gnt); else n_pass++;
            n_checks++; if (mem_wr !== 1'b0) $display("FAIL rst_mem_wr got=%b exp=0", mem_wr); else n_pass++;
            n_checks++; if (mem_rst !== 1'b1) $display("FAIL rst_mem_rst got=%b exp=1", mem_rst); else n_pass++;
            n_checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) $display("FAIL rst_rvalid got=%b%b exp=00", a_rvalid, b_rvalid); else n_pass++;
        end
        @(negedge clk); rsta = 0; #1;
        n_checks++; if (a_gnt !== 1'b0) $display("FAIL post_rst_a_gnt got=%b exp=0", a_gnt); else n_pass++;
        n_checks++; if (mem_wr !== 1'b0) $display("FAIL post_rst_mem_wr got=%b exp=0", mem_wr); else n_pass++;
        n_checks++; if (mem_rst !== 1'b0) $display("FAIL post_rst_mem_rst got=%b exp=0", mem_rst); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) $display("FAIL wr_gnt got=%b%b exp=10", a_gnt, b_gnt); else n_pass++;
        n_checks++; if (mem_wr !== 1'b1) $display("FAIL wr_mem_wr got=%b exp=1", mem_wr); else n_pass++;
        n_checks++; if (mem_index !== 4'd3 || mem_chan !== 3'd5) $display("FAIL wr_addr got=%0d/%0d exp=3/5", mem_index, mem_chan); else n_pass++;
        n_checks++; if (mem_din !== DA5) $display("FAIL wr_din got=%h exp=%h", mem_din, DA5); else n_pass++;
        @(negedge clk); a_req = 0; a_wr = 0;
    endtask

    task automatic test_read_latency;
        @(negedge clk); a_req = 1; a_wr = 0; a_index = 3; a_chan = 5; #1;
        n_checks++; if (a_gnt !== 1'b1 || mem_wr !== 1'b0) $display("FAIL rd_gnt got=%b wr=%b exp=1/0", a_gnt, mem_wr); else n_pass++;
        n_checks++; if (a_rvalid !== 1'b0) $display("FAIL rd_early_rvalid got=%b exp=0", a_rvalid); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (a_rvalid !== 1'b1) $display("FAIL rd_rvalid got=%b exp=1", a_rvalid); else n_pass++;
        n_checks++; if (a_rdata !== DA5) $display("FAIL rd_data got=%h exp=%h", a_rdata, DA5); else n_pass++;
        n_checks++; if (b_rvalid !== 1'b0) $display("FAIL rd_b_rvalid got=%b exp=0", b_rvalid); else n_pass++;
        @(negedge clk); a_req = 0;
        @(posedge clk); #1;
        n_checks++; if (a_rvalid !== 1'b0) $display("FAIL rd_late_rvalid got=%b exp=0", a_rvalid); else n_pass++;
    endtask

    task automatic test_write_then_read;
        @(negedge clk); a_req = 1; a_wr = 1; a_index = 2; a_chan = 1; a_wdata = D21; #1;
        n_checks++; if (a_gnt !== 1'b1 || mem_wr !== 1'b1) $display("FAIL wtr_wr got=%b/%b exp=1/1", a_gnt, mem_wr); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (a_rvalid !== 1'b0) $display("FAIL wtr_wr_rvalid got=%b exp=0", a_rvalid); else n_pass++;
        @(negedge clk); a_wr = 0;
        @(posedge clk); #1;
        n_checks++; if (a_rvalid !== 1'b1 || a_rdata !== D21) $display("FAIL wtr_rd got=%b/%h exp=1/%h", a_rvalid, a_rdata, D21); else n_pass++;
        @(negedge clk); a_req = 0;
    endtask

    task automatic test_contention;
        logic exp_a;
        @(negedge clk); b_req = 1; b_wr = 1; b_index = 1; b_chan = 2; b_wdata = D12; #1;
        n_checks++; if (b_gnt !== 1'b1 || mem_index !== 4'd1 || mem_din !== D12) $display("FAIL cont_bwr got=%b/%0d exp=1/1", b_gnt, mem_index); else n_pass++;
        @(negedge clk); b_req = 0; b_wr = 0; rsta = 1;
        @(negedge clk); rsta = 0;
        @(negedge clk);
        a_req = 1; a_wr = 0; a_index = 3; a_chan = 5;
        b_req = 1; b_wr = 0; b_index = 1; b_chan = 2;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_a = (i % 2 == 0);
            n_checks++; if (a_gnt !== exp_a || b_gnt !== !exp_a) $display("FAIL cont_gnt%0d got=%b%b exp=%b%b", i, a_gnt, b_gnt, exp_a, !exp_a); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (a_rvalid !== exp_a || b_rvalid !== !exp_a) $display("FAIL cont_rv%0d got=%b%b exp=%b%b", i, a_rvalid, b_rvalid, exp_a, !exp_a); else n_pass++;
            if (exp_a) begin
                n_checks++; if (a_rdata !== DA5) $display("FAIL cont_ad%0d got=%h exp=%h", i, a_rdata, DA5); else n_pass++;
            end else begin
                n_checks++; if (b_rdata !== D12) $display("FAIL cont_bd%0d got=%h exp=%h", i, b_rdata, D12); else n_pass++;
            end
        end
        @(negedge clk); a_req = 0; b_req = 0;
    endtask

    task automatic test_lock_burst;
        @(negedge clk); a_req = 1; a_wr = 1; a_index = 7; a_chan = 7; a_wdata = D77; #1;
        n_checks++; if (a_gnt !== 1'b1) $display("FAIL lk_pre got=%b exp=1", a_gnt); else n_pass++;
        @(negedge clk); a_wr = 0; a_index = 3; a_chan = 5;
        b_req = 1; b_wr = 1; b_index = 7;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            b_chan = 3'(i); b_wdata = burst_data(i); b_lock = (i < 3); #1;
            n_checks++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) $display("FAIL lk_gnt%0d got=%b%b exp=01", i, a_gnt, b_gnt); else n_pass++;
            n_checks++; if (mem_chan !== 3'(i) || mem_din !== burst_data(i)) $display("FAIL lk_mem%0d got=%0d/%h exp=%0d", i, mem_chan, mem_din, i); else n_pass++;
        end
        @(negedge clk); b_req = 0; b_lock = 0; b_wr = 0; #1;
        n_checks++; if (a_gnt !== 1'b1) $display("FAIL lk_a_after got=%b exp=1", a_gnt); else n_pass++;
        @(negedge clk); a_req = 0;
        b_req = 1; b_index = 7; b_chan = 2; #1;
        n_checks++; if (b_gnt !== 1'b1) $display("FAIL lk_rb_gnt got=%b exp=1", b_gnt); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (b_rvalid !== 1'b1 || b_rdata !== burst_data(2)) $display("FAIL lk_rb got=%b/%h exp=1/%h", b_rvalid, b_rdata, burst_data(2)); else n_pass++;
        @(negedge clk); b_req = 0;
    endtask

    task automatic test_lock_timeout;
        logic [11:0] pat;
        pat = 12'b1111_0_1111_0_11;
        @(negedge clk); a_req = 1; a_wr = 0; a_index = 3; a_chan = 5; #1;
        n_checks++; if (a_gnt !== 1'b1) $display("FAIL to_pre got=%b exp=1", a_gnt); else n_pass++;
        @(negedge clk);
        b_req = 1; b_wr = 1; b_index = 9; b_chan = 6; b_wdata = D77; b_lock = 1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_checks++; if (b_gnt !== pat[11-i] || a_gnt !== !pat[11-i]) $display("FAIL to_gnt%0d got=%b%b exp=%b%b", i, a_gnt, b_gnt, !pat[11-i], pat[11-i]); else n_pass++;
        end
        @(negedge clk); b_req = 0; #1;
        n_checks++; if (a_gnt !== 1'b0) $display("FAIL to_lock_idle got=%b exp=0", a_gnt); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (a_gnt !== 1'b1) $display("FAIL to_release got=%b exp=1", a_gnt); else n_pass++;
        @(negedge clk); a_req = 0; b_lock = 0; b_wr = 0;
    endtask

    task automatic test_reset_mid_lock;
        @(negedge clk); a_req = 0;
        b_req = 1; b_wr = 0; b_index = 1; b_chan = 2; b_lock = 1; #1;
        n_checks++; if (b_gnt !== 1'b1) $display("FAIL rml_b1 got=%b exp=1", b_gnt); else n_pass++;
        @(negedge clk); rsta = 1; a_req = 1; a_wr = 0; a_index = 3; a_chan = 5; #1;
        n_checks++; if (b_gnt !== 1'b0 || a_gnt !== 1'b0) $display("FAIL rml_gnt got=%b%b exp=00", a_gnt, b_gnt); else n_pass++;
        n_checks++; if (b_rvalid !== 1'b0) $display("FAIL rml_rv_rst got=%b exp=0", b_rvalid); else n_pass++;
        n_checks++; if (mem_rst !== 1'b1) $display("FAIL rml_mem_rst got=%b exp=1", mem_rst); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (b_rvalid !== 1'b0) $display("FAIL rml_rv_next got=%b exp=0", b_rvalid); else n_pass++;
        @(negedge clk); rsta = 0; #1;
        n_checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) $display("FAIL rml_blk got=%b%b exp=00", a_gnt, b_gnt); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) $display("FAIL rml_tie got=%b%b exp=10", a_gnt, b_gnt); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (a_rvalid !== 1'b1 || a_rdata !== DA5) $display("FAIL rml_ard got=%b/%h exp=1/%h", a_rvalid, a_rdata, DA5); else n_pass++;
        @(negedge clk); a_req = 0; b_req = 0; b_lock = 0;
    endtask

    initial begin
        rsta = 1;
        a_req = 0; a_wr = 0; a_index = 0; a_chan = 0; a_wdata = '0;
        b_req = 0; b_wr = 0; b_index = 0; b_chan = 0; b_wdata = '0;
        b_lock = 0;
        test_reset;
        test_read_latency;
        test_write_then_read;
        test_contention;
        test_lock_burst;
        test_lock_timeout;
        test_reset_mid_lock;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
